// File: rtl/salsa_blockmix.sv
`default_nettype none
// ============================================================================
// Module   : salsa_blockmix
// Purpose  : Sequences an external pipelined Salsa double-round core to compute
//            scrypt BlockMix (r=1): Y0 = Salsa(B1^B0), Y1 = Salsa(Y0^B1).
//            Provides the core input mux, round counting, the per-word
//            feed-forward add and the BlockMix xor chaining.
// Revision : 1.0 - initial release
// ============================================================================
module salsa_blockmix #(
    parameter int DR    = 4,
    parameter int JBITS = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1023:0]     din,
    output logic              busy,
    output logic              done,
    output logic [1023:0]     dout,
    output logic [JBITS-1:0]  jaddr,
    output logic [511:0]      core_xx,
    input  logic [511:0]      core_out
);

    // Counter wide enough for 0 .. 2*DR-1
    localparam int              c_CW       = (2 * DR > 1) ? $clog2(2 * DR) : 1;
    localparam logic [c_CW-1:0] c_CYC_LAST = c_CW'(2 * DR - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FEED  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CW-1:0]    r_cyc;
    logic               r_half;
    logic               r_busy;
    logic               r_done;
    logic [511:0]       r_t;
    logic [511:0]       r_bh;
    logic [1023:0]      r_dout;
    logic [JBITS-1:0]   r_jaddr;
    logic [511:0]       w_sum;

    // Feed-forward add: sixteen isolated 32-bit lanes, no carry between words
    for (genvar k = 0; k < 16; k++) begin : g_word_add
        assign w_sum[32*k +: 32] = core_out[32*k +: 32] + r_t[32*k +: 32];
    end

    // Core input: seed with T on the first round cycle, then recirculate
    always_comb begin
        core_xx = r_t;
        if (r_state == ST_ROUND && r_cyc != '0) begin
            core_xx = core_out;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_ROUND;
            ST_ROUND: if (r_cyc == c_CYC_LAST) w_state_nxt = ST_FEED;
            ST_FEED:  w_state_nxt = r_half ? ST_DONE : ST_ROUND;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: load, count rounds, feed-forward and chain the two halves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc   <= '0;
            r_half  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_t     <= '0;
            r_bh    <= '0;
            r_dout  <= '0;
            r_jaddr <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bh   <= din[1023:512];
                        r_t    <= din[1023:512] ^ din[511:0];
                        r_half <= 1'b0;
                        r_cyc  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_cyc <= r_cyc + c_CW'(1);
                end
                ST_FEED: begin
                    if (!r_half) begin
                        r_dout[511:0] <= w_sum;
                        r_t           <= w_sum ^ r_bh;
                        r_half        <= 1'b1;
                        r_cyc         <= '0;
                    end else begin
                        r_dout[1023:512] <= w_sum;
                        r_jaddr          <= w_sum[JBITS-1:0];
                        r_done           <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign dout  = r_dout;
    assign jaddr = r_jaddr;

endmodule
`default_nettype wire

// File: tb/tb_salsa_blockmix.sv
`default_nettype none
// ============================================================================
// Module   : tb_salsa_blockmix
// Purpose  : Self-checking bench for salsa_blockmix with a behavioural
//            two-stage double-round core and a switchable stub core output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_salsa_blockmix;

    localparam int DR    = 4;
    localparam int JBITS = 10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [1023:0]   din;
    logic            busy;
    logic            done;
    logic [1023:0]   dout;
    logic [JBITS-1:0] jaddr;
    logic [511:0]    core_xx;
    logic [511:0]    core_out;

    logic            stub_en;
    logic [511:0]    stub_val;
    logic [511:0]    r_core_s1;
    logic [511:0]    r_core_s2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [19:0] c_BUSY_EXP = 20'h7FFFF;
    localparam logic [19:0] c_DONE_EXP = 20'h40000;

    always #5 clk = ~clk;

    salsa_blockmix #(.DR(DR), .JBITS(JBITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .jaddr    (jaddr),
        .core_xx  (core_xx),
        .core_out (core_out)
    );

    // ---------------- Salsa reference functions ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] ta, tb, tc, td;
        tb = b ^ rotl(a + d, 7);
        tc = c ^ rotl(tb + a, 9);
        td = d ^ rotl(tc + tb, 13);
        ta = a ^ rotl(td + tc, 18);
        return {td, tc, tb, ta};
    endfunction

    function automatic logic [511:0] dround(input logic [511:0] x);
        logic [31:0]  w [16];
        int           q [8][4];
        logic [127:0] r;
        logic [511:0] y;
        q = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
              '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}};
        for (int i = 0; i < 16; i++) w[i] = x[32*i +: 32];
        for (int g = 0; g < 8; g++) begin
            r = qr(w[q[g][0]], w[q[g][1]], w[q[g][2]], w[q[g][3]]);
            w[q[g][0]] = r[31:0];
            w[q[g][1]] = r[63:32];
            w[q[g][2]] = r[95:64];
            w[q[g][3]] = r[127:96];
        end
        for (int i = 0; i < 16; i++) y[32*i +: 32] = w[i];
        return y;
    endfunction

    function automatic logic [511:0] wadd(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] s;
        logic [31:0]  aw, bw;
        for (int i = 0; i < 16; i++) begin
            aw = a[32*i +: 32];
            bw = b[32*i +: 32];
            s[32*i +: 32] = aw + bw;
        end
        return s;
    endfunction

    function automatic logic [511:0] salsa8(input logic [511:0] x);
        logic [511:0] y;
        y = x;
        for (int i = 0; i < DR; i++) y = dround(y);
        return wadd(y, x);
    endfunction

    // BlockMix r=1; with stub the "hash" is stub_val added to its input
    function automatic logic [1023:0] ref_blockmix(input logic [1023:0] b, input bit stub,
                                                   input logic [511:0] k);
        logic [511:0] x, y0, y1;
        x  = b[1023:512] ^ b[511:0];
        y0 = stub ? wadd(k, x) : salsa8(x);
        x  = y0 ^ b[1023:512];
        y1 = stub ? wadd(k, x) : salsa8(x);
        return {y1, y0};
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural core: double round with two-cycle registered latency
    always @(posedge clk) begin
        r_core_s1 <= dround(core_xx);
        r_core_s2 <= r_core_s1;
    end
    assign core_out = stub_en ? stub_val : r_core_s2;

    // ---------------- Driver: one operation, called at a negedge ----------------
    task automatic run_op(input logic [1023:0] b, input bit hold,
                          output logic [19:0] bt, output logic [19:0] dt,
                          output logic [1023:0] d, output logic [JBITS-1:0] j);
        bt = '0; dt = '0; d = '0; j = '0;
        start = 1'b1;
        din   = b;
        @(posedge clk);
        @(negedge clk);
        bt[0] = busy;
        dt[0] = done;
        if (!hold) start = 1'b0;
        din = rand1024();
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            bt[k] = busy;
            dt[k] = done;
            if (done) begin
                d = dout;
                j = jaddr;
            end
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
        n_checks++; if (jaddr !== '0) begin n_fail++; $display("FAIL reset_jaddr got %h want 0", jaddr); end
    endtask

    task automatic test_zero();
        logic [19:0] bt, dt; logic [1023:0] d; logic [JBITS-1:0] j;
        run_op('0, 1'b0, bt, dt, d, j);
        n_checks++; if (bt !== c_BUSY_EXP) begin n_fail++; $display("FAIL zero_busy_trace got %h want %h", bt, c_BUSY_EXP); end
        n_checks++; if (dt !== c_DONE_EXP) begin n_fail++; $display("FAIL zero_done_trace got %h want %h", dt, c_DONE_EXP); end
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL zero_dout got %h want 0", d); end
        n_checks++; if (j !== '0) begin n_fail++; $display("FAIL zero_jaddr got %h want 0", j); end
    endtask

    task automatic test_equal_halves();
        logic [19:0] bt, dt; logic [1023:0] d, b, exp; logic [JBITS-1:0] j;
        logic [511:0] rfc;
        rfc = {32'h5ec2b8b8, 32'h8dc6ebed, 32'h2948c709, 32'h291d0276,
               32'h32aac55a, 32'h4b1e1214, 32'h853d9bdf, 32'h19f324ee,
               32'h1d3bcd6d, 32'h1146f80d, 32'hb5c1618c, 32'h5b55eeba,
               32'h268f7141, 32'he640a97c, 32'h86c93e4f, 32'h219a877e};
        for (int t = 0; t < 2; t++) begin
            if (t == 0) b = {32{32'h01234567}};
            else        b = {rfc, rfc};
            exp = ref_blockmix(b, 1'b0, '0);
            run_op(b, 1'b0, bt, dt, d, j);
            n_checks++; if (dt !== c_DONE_EXP) begin n_fail++; $display("FAIL eq%0d_done_trace got %h want %h", t, dt, c_DONE_EXP); end
            n_checks++; if (d[511:0] !== '0) begin n_fail++; $display("FAIL eq%0d_y0 got %h want 0", t, d[511:0]); end
            n_checks++; if (d[1023:512] !== salsa8(b[1023:512])) begin n_fail++; $display("FAIL eq%0d_y1 got %h want %h", t, d[1023:512], salsa8(b[1023:512])); end
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL eq%0d_dout got %h want %h", t, d, exp); end
        end
    endtask

    task automatic test_random();
        logic [19:0] bt, dt; logic [1023:0] d, b, exp; logic [JBITS-1:0] j;
        for (int t = 0; t < 4; t++) begin
            b   = rand1024();
            exp = ref_blockmix(b, 1'b0, '0);
            run_op(b, 1'b0, bt, dt, d, j);
            n_checks++; if (bt !== c_BUSY_EXP) begin n_fail++; $display("FAIL rnd%0d_busy_trace got %h want %h", t, bt, c_BUSY_EXP); end
            n_checks++; if (dt !== c_DONE_EXP) begin n_fail++; $display("FAIL rnd%0d_done_trace got %h want %h", t, dt, c_DONE_EXP); end
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rnd%0d_dout got %h want %h", t, d, exp); end
            n_checks++; if (j !== exp[512 +: JBITS]) begin n_fail++; $display("FAIL rnd%0d_jaddr got %h want %h", t, j, exp[512 +: JBITS]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bt1, dt1, bt2, dt2; logic [1023:0] d1, d2, b1, b2, e1, e2;
        logic [JBITS-1:0] j1, j2;
        b1 = rand1024();
        b2 = rand1024();
        e1 = ref_blockmix(b1, 1'b0, '0);
        e2 = ref_blockmix(b2, 1'b0, '0);
        run_op(b1, 1'b1, bt1, dt1, d1, j1);
        run_op(b2, 1'b1, bt2, dt2, d2, j2);
        start = 1'b0;
        n_checks++; if (bt1 !== c_BUSY_EXP) begin n_fail++; $display("FAIL b2b_busy1 got %h want %h", bt1, c_BUSY_EXP); end
        n_checks++; if (dt1 !== c_DONE_EXP) begin n_fail++; $display("FAIL b2b_done1 got %h want %h", dt1, c_DONE_EXP); end
        n_checks++; if (bt2 !== c_BUSY_EXP) begin n_fail++; $display("FAIL b2b_busy2 got %h want %h", bt2, c_BUSY_EXP); end
        n_checks++; if (dt2 !== c_DONE_EXP) begin n_fail++; $display("FAIL b2b_done2 got %h want %h", dt2, c_DONE_EXP); end
        n_checks++; if (d1 !== e1) begin n_fail++; $display("FAIL b2b_dout1 got %h want %h", d1, e1); end
        n_checks++; if (d2 !== e2) begin n_fail++; $display("FAIL b2b_dout2 got %h want %h", d2, e2); end
    endtask

    task automatic test_reset_mid();
        logic [19:0] bt, dt; logic [1023:0] d; logic [JBITS-1:0] j;
        int ndone;
        start = 1'b1;
        din   = rand1024();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL abort_dout got %h want 0", dout); end
        n_checks++; if (jaddr !== '0) begin n_fail++; $display("FAIL abort_jaddr got %h want 0", jaddr); end
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_stray_done got %0d want 0", ndone); end
        run_op('0, 1'b0, bt, dt, d, j);
        n_checks++; if (dt !== c_DONE_EXP) begin n_fail++; $display("FAIL abort_rerun_done got %h want %h", dt, c_DONE_EXP); end
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL abort_rerun_dout got %h want 0", d); end
    endtask

    task automatic test_word_carry();
        logic [19:0] bt, dt; logic [1023:0] d, b, exp; logic [JBITS-1:0] j;
        stub_en  = 1'b1;
        stub_val = {16{32'hFFFFFFFF}};
        b = {{16{32'h00000001}}, 512'h0};
        run_op(b, 1'b0, bt, dt, d, j);
        n_checks++; if (d !== '0) begin n_fail++; $display("FAIL carry_ones got %h want 0", d); end
        for (int t = 0; t < 2; t++) begin
            stub_val = rand1024() >> 512;
            b        = rand1024();
            exp      = ref_blockmix(b, 1'b1, stub_val);
            run_op(b, 1'b0, bt, dt, d, j);
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL carry_rnd%0d got %h want %h", t, d, exp); end
        end
        stub_en = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        din      = '0;
        stub_en  = 1'b0;
        stub_val = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero();
        test_equal_halves();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_reset_mid();
        test_word_carry();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
